// File: rtl/operand_stage.sv
// operand_stage: register-file read and ALU operand register; define OPERAND_STAGE_BYPASS_EN for write-to-read forwarding
module operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rt_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic [15:0]               imm,
  input  logic                      imm_sext,
  input  logic                      src_b_imm,
  input  logic [2:0]                alu_op_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     A,
  output logic [DATA_WIDTH-1:0]     B,
  output logic [2:0]                ALUop,
  output logic [REG_ADDR_WIDTH-1:0] dest,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data
);
  localparam int NREG = 1 << REG_ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [DATA_WIDTH-1:0] rs_data, rt_data, ext_imm;
  logic wb_hit;
  assign in_ready = !out_valid || out_ready;
  assign wb_hit = wb_en && wb_addr != '0;
  assign ext_imm = {{(DATA_WIDTH-16){imm[15] & imm_sext}}, imm};
`ifdef OPERAND_STAGE_BYPASS_EN
  always_comb begin
    rs_data = rs_addr == '0 ? '0 : (wb_hit && wb_addr == rs_addr) ? wb_data : regs[rs_addr];
    rt_data = rt_addr == '0 ? '0 : (wb_hit && wb_addr == rt_addr) ? wb_data : regs[rt_addr];
  end
`else
  always_comb begin
    rs_data = rs_addr == '0 ? '0 : regs[rs_addr];
    rt_data = rt_addr == '0 ? '0 : regs[rt_addr];
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      out_valid <= 1'b0;
      A <= '0;
      B <= '0;
      ALUop <= '0;
      dest <= '0;
    end else begin
      if (wb_hit) regs[wb_addr] <= wb_data;
      if (in_valid && in_ready) begin
        out_valid <= 1'b1;
        A <= rs_data;
        B <= src_b_imm ? ext_imm : rt_data;
        ALUop <= alu_op_in;
        dest <= rd_addr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: directed checks of operand_stage handshake, extension, reg0, stall, bypass and reset
module tb_operand_stage;
  logic clk = 0;
  logic rst, in_valid, in_ready, imm_sext, src_b_imm, out_valid, out_ready, wb_en;
  logic [4:0] rs_addr, rt_addr, rd_addr, dest, wb_addr;
  logic [15:0] imm;
  logic [2:0] alu_op_in, ALUop;
  logic [31:0] A, B, wb_data;
  int total = 0, bad = 0;

  operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .imm(imm),
    .imm_sext(imm_sext), .src_b_imm(src_b_imm), .alu_op_in(alu_op_in),
    .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B), .ALUop(ALUop),
    .dest(dest), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [4:0] d);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".A"}, A, a);
    chk({tag, ".B"}, B, b);
    chk({tag, ".ALUop"}, 32'(ALUop), 32'(op));
    chk({tag, ".dest"}, 32'(dest), 32'(d));
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] im, input logic sx, input logic bi, input logic [2:0] op);
    in_valid = 1; rs_addr = rs; rt_addr = rt; rd_addr = rd;
    imm = im; imm_sext = sx; src_b_imm = bi; alu_op_in = op;
  endtask

  initial begin
    rst = 1; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    instr(5'd1, 5'd2, 5'd3, 16'h1111, 1'b0, 1'b1, 3'd5);
    step(); step();
    outs("reset", 1'b0, 32'h0, 32'h0, 3'd0, 5'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    rst = 0; in_valid = 0; wb_en = 1; wb_addr = 5; wb_data = 32'h7;
    step();
    wb_en = 0;
    instr(5'd5, 5'd0, 5'd9, 16'h0, 1'b0, 1'b0, 3'b010);
    step();
    outs("basic", 1'b1, 32'h7, 32'h0, 3'b010, 5'd9);

    instr(5'd0, 5'd5, 5'd1, 16'h8000, 1'b1, 1'b1, 3'd1);
    step();
    outs("sext", 1'b1, 32'h0, 32'hFFFF_8000, 3'd1, 5'd1);
    imm_sext = 0;
    step();
    outs("zext", 1'b1, 32'h0, 32'h0000_8000, 3'd1, 5'd1);

    in_valid = 0; wb_en = 1; wb_addr = 0; wb_data = 32'hDEAD_BEEF;
    step();
    outs("drain", 1'b0, 32'h0, 32'h0000_8000, 3'd1, 5'd1);
    wb_en = 0;
    instr(5'd0, 5'd5, 5'd6, 16'h0, 1'b0, 1'b0, 3'd4);
    step();
    outs("reg0", 1'b1, 32'h0, 32'h7, 3'd4, 5'd6);

    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      instr(5'(5 - i * 5), 5'd5, 5'(10 + i), 16'(i), 1'b0, 1'(i), 3'(i + 5));
      #1;
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      step();
      outs("stall", 1'b1, 32'h0, 32'h7, 3'd4, 5'd6);
    end
    out_ready = 1;
    instr(5'd5, 5'd0, 5'd12, 16'hFFFF, 1'b1, 1'b1, 3'd7);
    #1;
    chk("release.in_ready", 32'(in_ready), 32'd1);
    step();
    outs("release", 1'b1, 32'h7, 32'hFFFF_FFFF, 3'd7, 5'd12);

    instr(5'd4, 5'd4, 5'd2, 16'h0, 1'b0, 1'b0, 3'd3);
    wb_en = 1; wb_addr = 4; wb_data = 32'h1234;
    step();
    wb_en = 0;
`ifdef OPERAND_STAGE_BYPASS_EN
    outs("same_cycle", 1'b1, 32'h1234, 32'h1234, 3'd3, 5'd2);
`else
    outs("same_cycle", 1'b1, 32'h0, 32'h0, 3'd3, 5'd2);
`endif
    step();
    outs("after_wb", 1'b1, 32'h1234, 32'h1234, 3'd3, 5'd2);

    out_ready = 0; rst = 1;
    step();
    outs("rst_stall", 1'b0, 32'h0, 32'h0, 3'd0, 5'd0);
    rst = 0; out_ready = 1;
    instr(5'd5, 5'd4, 5'd8, 16'h0, 1'b0, 1'b0, 3'd6);
    step();
    outs("rst_regs", 1'b1, 32'h0, 32'h0, 3'd6, 5'd8);
    in_valid = 0;
    step();
    chk("final.out_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
